// File: rtl/regbank.sv
// Byte-strobed register bank with registered 1-cycle read, same-index write bypass,
// out-of-range error flags, per-entry dirty tracking and synchronous clear.
module regbank #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [IDXW-1:0]    wr_idx,
  input  logic [WIDTH/8-1:0] wr_strb,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rd_en,
  input  logic [IDXW-1:0]    rd_idx,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid,
  output logic               rd_err,
  output logic               wr_err,
  output logic [DEPTH-1:0]   dirty
);

  localparam int unsigned NBYTES = WIDTH / 8;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] dirty_q, dirty_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_err_q, rd_err_d;
  logic             wr_err_q, wr_err_d;

  logic [31:0]      wr_idx_ext, rd_idx_ext;
  logic             wr_in_range, rd_in_range;
  logic             wr_any_strb;
  logic [WIDTH-1:0] wr_mask;
  logic [DEPTH-1:0] entry_we;
  logic [WIDTH-1:0] rd_stored;
  logic [WIDTH-1:0] rd_word;

  // Widen indices so range checks work for non-power-of-two depths.
  assign wr_idx_ext  = 32'(wr_idx);
  assign rd_idx_ext  = 32'(rd_idx);
  assign wr_in_range = (wr_idx_ext < DEPTH);
  assign rd_in_range = (rd_idx_ext < DEPTH);
  assign wr_any_strb = |wr_strb;

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < NBYTES; b++) begin
      wr_mask[8*b +: 8] = {8{wr_strb[b]}};
    end
  end

  // One decoded enable per entry; clear suppresses all writes.
  always_comb begin
    entry_we = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_we[i] = wr_en && wr_in_range && wr_any_strb && !clr && (wr_idx_ext == 32'(i));
    end
  end

  always_comb begin
    dirty_d = dirty_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (clr) begin
        mem_d[i]   = '0;
        dirty_d[i] = 1'b0;
      end else if (entry_we[i]) begin
        mem_d[i]   = (mem_q[i] & ~wr_mask) | (wr_data & wr_mask);
        dirty_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_stored = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx_ext == 32'(i)) begin
        rd_stored = mem_q[i];
      end
    end
  end

  // Same-index bypass uses the raw write request so a concurrent clear still
  // returns the merged value of this cycle.
  always_comb begin
    rd_word = rd_stored;
    if (wr_en && wr_in_range && (wr_idx == rd_idx)) begin
      rd_word = (rd_stored & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    rd_err_d   = rd_en && !rd_in_range;
    wr_err_d   = wr_en && !wr_in_range;
    if (rd_en) begin
      rd_data_d = rd_in_range ? rd_word : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      dirty_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      dirty_q    <= dirty_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign wr_err   = wr_err_q;
  assign dirty    = dirty_q;

endmodule

// File: tb/tb_regbank.sv
// Random plus directed bench for regbank; a DEPTH=4 and a DEPTH=3 instance share
// one stimulus stream and are both checked against a byte-level array model.
module tb_regbank;

  logic        clk = 1'b0;
  logic        rst_n, clr, wr_en, rd_en;
  logic [1:0]  wr_idx, rd_idx;
  logic [3:0]  wr_strb;
  logic [31:0] wr_data;

  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, rd_err_a, rd_err_b, wr_err_a, wr_err_b;
  logic [3:0]  dirty_a;
  logic [2:0]  dirty_b;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  // Model state: index 0 models DEPTH=4, index 1 models DEPTH=3.
  logic [31:0] m_mem [2][4];
  logic [3:0]  m_dirty [2];
  logic [31:0] e_rd_data [2];
  logic        e_rd_valid [2];
  logic        e_rd_err [2];
  logic        e_wr_err [2];

  always #5 clk = ~clk;

  regbank #(.WIDTH(32), .DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_strb(wr_strb), .wr_data(wr_data), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_err(rd_err_a),
    .wr_err(wr_err_a), .dirty(dirty_a)
  );

  regbank #(.WIDTH(32), .DEPTH(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_strb(wr_strb), .wr_data(wr_data), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_err(rd_err_b),
    .wr_err(wr_err_b), .dirty(dirty_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the current inputs to the model as if a rising edge occurred.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int unsigned d;
      logic [31:0] v;
      d = (k == 0) ? 4 : 3;
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) m_mem[k][i] = '0;
        m_dirty[k] = '0;
        e_rd_data[k] = '0;
        e_rd_valid[k] = 1'b0;
        e_rd_err[k] = 1'b0;
        e_wr_err[k] = 1'b0;
      end else begin
        e_rd_valid[k] = rd_en;
        e_rd_err[k] = rd_en && (int'(rd_idx) >= int'(d));
        if (rd_en) begin
          if (int'(rd_idx) < int'(d)) begin
            v = m_mem[k][rd_idx];
            if (wr_en && wr_idx == rd_idx)
              for (int b = 0; b < 4; b++) if (wr_strb[b]) v[8*b +: 8] = wr_data[8*b +: 8];
            e_rd_data[k] = v;
          end else begin
            e_rd_data[k] = '0;
          end
        end
        e_wr_err[k] = wr_en && (int'(wr_idx) >= int'(d));
        if (clr) begin
          for (int i = 0; i < 4; i++) m_mem[k][i] = '0;
          m_dirty[k] = '0;
        end else if (wr_en && int'(wr_idx) < int'(d)) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) begin
              m_mem[k][wr_idx][8*b +: 8] = wr_data[8*b +: 8];
              m_dirty[k][wr_idx] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  // Inputs are driven 2 time units after a rising edge; the model advances after
  // the falling-edge compare so expectations always describe the DUT's next edge.
  task automatic step();
    @(negedge clk);
    #1;
    model_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic we, input logic [1:0] wi, input logic [3:0] ws,
                       input logic [31:0] wd, input logic re, input logic [1:0] ri,
                       input logic cl);
    wr_en = we; wr_idx = wi; wr_strb = ws; wr_data = wd;
    rd_en = re; rd_idx = ri; clr = cl;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rd_data_a", rd_data_a, e_rd_data[0]);
      chk("rd_valid_a", 32'(rd_valid_a), 32'(e_rd_valid[0]));
      chk("rd_err_a", 32'(rd_err_a), 32'(e_rd_err[0]));
      chk("wr_err_a", 32'(wr_err_a), 32'(e_wr_err[0]));
      chk("dirty_a", 32'(dirty_a), 32'(m_dirty[0]));
      chk("rd_data_b", rd_data_b, e_rd_data[1]);
      chk("rd_valid_b", 32'(rd_valid_b), 32'(e_rd_valid[1]));
      chk("rd_err_b", 32'(rd_err_b), 32'(e_rd_err[1]));
      chk("wr_err_b", 32'(wr_err_b), 32'(e_wr_err[1]));
      chk("dirty_b", 32'(dirty_b), 32'(m_dirty[1]));
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    step();
    step();
    chk("reset_rd_data", rd_data_a, 32'h0);
    chk("reset_dirty", 32'(dirty_a), 32'h0);
    chk_on = 1'b1;
    rst_n = 1'b1;

    // First cycle after reset: write idx 2, then read it back.
    drive(1'b1, 2'd2, 4'hF, 32'hDEADBEEF, 1'b0, 2'd0, 1'b0);
    step();
    drive(1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 2'd2, 1'b0);
    step();
    chk("lit_rd_beef", rd_data_a, 32'hDEADBEEF);
    chk("lit_rd_valid", 32'(rd_valid_a), 32'h1);
    chk("lit_dirty_0100", 32'(dirty_a), 32'h4);
    drive(1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 2'd1, 1'b0);
    step();
    chk("lit_rd_idx1_zero", rd_data_a, 32'h0);
    drive(1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    step();
    chk("lit_hold_data", rd_data_a, 32'h0);
    chk("lit_hold_valid", 32'(rd_valid_a), 32'h0);

    // Same-index read-during-write bypass with partial strobes.
    drive(1'b1, 2'd1, 4'hF, 32'h11223344, 1'b0, 2'd0, 1'b0);
    step();
    drive(1'b1, 2'd1, 4'b0101, 32'hAABBCCDD, 1'b1, 2'd1, 1'b0);
    step();
    chk("lit_bypass", rd_data_a, 32'h11BB33DD);
    drive(1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 2'd1, 1'b0);
    step();
    chk("lit_merged_store", rd_data_a, 32'h11BB33DD);

    // Index 3: out of range for the DEPTH=3 instance only.
    drive(1'b1, 2'd3, 4'hF, 32'h5, 1'b0, 2'd0, 1'b0);
    step();
    chk("lit_wr_err_b", 32'(wr_err_b), 32'h1);
    chk("lit_wr_err_a", 32'(wr_err_a), 32'h0);
    chk("lit_dirty_b", 32'(dirty_b), 32'h6);
    drive(1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 2'd3, 1'b0);
    step();
    chk("lit_wr_err_pulse", 32'(wr_err_b), 32'h0);
    chk("lit_oor_rd_data", rd_data_b, 32'h0);
    chk("lit_oor_rd_err", 32'(rd_err_b), 32'h1);
    chk("lit_oor_rd_valid", 32'(rd_valid_b), 32'h1);
    chk("lit_a_idx3", rd_data_a, 32'h5);

    // Clear beats a simultaneous write.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 4'hF, $urandom | 32'h1, 1'b0, 2'd0, 1'b0);
      step();
    end
    drive(1'b1, 2'd0, 4'hF, 32'h7, 1'b0, 2'd0, 1'b1);
    step();
    chk("lit_clr_dirty", 32'(dirty_a), 32'h0);
    drive(1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 2'd0, 1'b0);
    step();
    chk("lit_clr_rd0", rd_data_a, 32'h0);

    // Reset drops a concurrent write.
    drive(1'b1, 2'd0, 4'hF, 32'h1, 1'b0, 2'd0, 1'b0);
    step();
    rst_n = 1'b0;
    drive(1'b1, 2'd0, 4'hF, 32'h9, 1'b1, 2'd0, 1'b0);
    step();
    chk("lit_rst_valid", 32'(rd_valid_a), 32'h0);
    chk("lit_rst_dirty", 32'(dirty_a), 32'h0);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 2'd0, 1'b0);
    step();
    chk("lit_post_rst_rd", rd_data_a, 32'h0);
    chk("lit_post_rst_err", 32'(rd_err_a | wr_err_a), 32'h0);

    // Back-to-back writes to 0 and 3, then consecutive reads.
    drive(1'b1, 2'd0, 4'hF, 32'hA, 1'b0, 2'd0, 1'b0);
    step();
    drive(1'b1, 2'd3, 4'hF, 32'hB, 1'b0, 2'd0, 1'b0);
    step();
    drive(1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 2'd0, 1'b0);
    step();
    chk("lit_b2b_rd0", rd_data_a, 32'hA);
    drive(1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 2'd3, 1'b0);
    step();
    chk("lit_b2b_rd3", rd_data_a, 32'hB);
    drive(1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 2'd1, 1'b0);
    step();
    chk("lit_idx1_untouched", rd_data_a, 32'h0);
    drive(1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 2'd2, 1'b0);
    step();
    chk("lit_idx2_untouched", rd_data_a, 32'h0);

    // Random traffic with occasional clear and reset.
    for (int n = 0; n < 2000; n++) begin
      rst_n = ($urandom_range(63) != 0);
      drive($urandom_range(1) == 1, 2'($urandom_range(3)), 4'($urandom_range(15)),
            $urandom, $urandom_range(1) == 1, 2'($urandom_range(3)),
            $urandom_range(31) == 0);
      step();
    end
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    step();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
